// File: rtl/uart_alu_host.sv
// Host-side UART ALU command initiator: frames an opcode plus N operands into the
// ALU byte packet, then collects the 4-byte little-endian result or times out.
module uart_alu_host #(
   parameter int unsigned timeout_cycles_p = 1000000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [7:0]  cmd_opcode_i,
   input  logic [7:0]  cmd_count_i,
   input  logic        op_valid_i,
   output logic        op_ready_o,
   input  logic [31:0] op_data_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_timeout_o,
   output logic        busy_o
);
   localparam int unsigned TMR_W = $clog2(timeout_cycles_p + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(timeout_cycles_p);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_OPND = 3'd2,
      S_WAIT = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_opcode;
   logic [7:0]       r_count;
   logic [15:0]      r_len;
   logic [1:0]       r_idx;
   logic [1:0]       r_bidx;
   logic [7:0]       r_op_acc;
   logic             r_held;
   logic [31:0]      r_shift;
   logic [31:0]      r_result;
   logic [1:0]       r_k;
   logic             r_timeout;
   logic [TMR_W-1:0] r_timer;

   logic w_cmd_hs, w_op_hs, w_tx_hs, w_rx_hs, w_rsp_hs;
   logic w_hlast, w_blast, w_ops_left, w_tmr_done;

   assign w_cmd_hs   = cmd_valid_i & cmd_ready_o;
   assign w_op_hs    = op_valid_i & op_ready_o;
   assign w_tx_hs    = tx_valid_o & tx_ready_i;
   assign w_rx_hs    = rx_valid_i & rx_ready_o;
   assign w_rsp_hs   = rsp_valid_o & rsp_ready_i;
   assign w_hlast    = (r_idx == 2'd3);
   assign w_blast    = (r_bidx == 2'd3);
   assign w_ops_left = (r_op_acc != r_count);
   assign w_tmr_done = (r_timer == TMR_MAX);

   assign busy_o        = (r_state != S_IDLE);
   assign rsp_data_o    = r_result;
   assign rsp_timeout_o = r_timeout;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_hs) w_state_nxt = S_HDR;
            else          w_state_nxt = S_IDLE;
         end
         S_HDR: begin
            if (w_tx_hs && w_hlast) w_state_nxt = (r_count != 8'd0) ? S_OPND : S_WAIT;
            else                    w_state_nxt = S_HDR;
         end
         S_OPND: begin
            if (w_tx_hs && w_blast && !w_ops_left) w_state_nxt = S_WAIT;
            else                                   w_state_nxt = S_OPND;
         end
         S_WAIT: begin
            if (w_rx_hs)         w_state_nxt = (r_k == 2'd3) ? S_RSP : S_WAIT;
            else if (w_tmr_done) w_state_nxt = S_RSP;
            else                 w_state_nxt = S_WAIT;
         end
         S_RSP: begin
            if (w_rsp_hs) w_state_nxt = S_IDLE;
            else          w_state_nxt = S_RSP;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode; the next operand may load on the cycle the last byte of the current one leaves
   always_comb begin
      cmd_ready_o = 1'b0;
      op_ready_o  = 1'b0;
      tx_valid_o  = 1'b0;
      tx_data_o   = 8'h00;
      rx_ready_o  = 1'b0;
      rsp_valid_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready_o = ~rst_i;
            rx_ready_o  = 1'b1;
         end
         S_HDR: begin
            rx_ready_o = 1'b1;
            tx_valid_o = 1'b1;
            op_ready_o = w_ops_left & ~r_held;
            case (r_idx)
               2'd0:    tx_data_o = r_opcode;
               2'd1:    tx_data_o = 8'h00;
               2'd2:    tx_data_o = r_len[7:0];
               default: tx_data_o = r_len[15:8];
            endcase
         end
         S_OPND: begin
            rx_ready_o = 1'b1;
            tx_valid_o = r_held;
            op_ready_o = w_ops_left & (~r_held | (tx_ready_i & w_blast));
            if (r_held) tx_data_o = r_shift[7:0];
            else        tx_data_o = 8'h00;
         end
         S_WAIT: begin
            rx_ready_o = 1'b1;
         end
         S_RSP: begin
            rsp_valid_o = 1'b1;
         end
         default: begin
            rx_ready_o = 1'b0;
         end
      endcase
   end

   // Datapath: packet fields, operand shifter, result assembly and response timer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_opcode  <= 8'h00;
         r_count   <= 8'h00;
         r_len     <= 16'h0000;
         r_idx     <= 2'd0;
         r_bidx    <= 2'd0;
         r_op_acc  <= 8'h00;
         r_held    <= 1'b0;
         r_shift   <= 32'h0000_0000;
         r_result  <= 32'h0000_0000;
         r_k       <= 2'd0;
         r_timeout <= 1'b0;
         r_timer   <= {TMR_W{1'b0}};
      end else begin
         r_timer <= {TMR_W{1'b0}};
         if (w_cmd_hs) begin
            r_opcode  <= cmd_opcode_i;
            r_count   <= cmd_count_i;
            r_len     <= 16'd4 + {6'd0, cmd_count_i, 2'b00};
            r_idx     <= 2'd0;
            r_bidx    <= 2'd0;
            r_op_acc  <= 8'h00;
            r_held    <= 1'b0;
            r_result  <= 32'h0000_0000;
            r_k       <= 2'd0;
            r_timeout <= 1'b0;
         end
         if (r_state == S_HDR && w_tx_hs) begin
            r_idx <= r_idx + 2'd1;
         end
         if (w_op_hs) begin
            r_shift  <= op_data_i;
            r_held   <= 1'b1;
            r_bidx   <= 2'd0;
            r_op_acc <= r_op_acc + 8'd1;
         end else if (r_state == S_OPND && w_tx_hs) begin
            r_shift <= {8'h00, r_shift[31:8]};
            r_bidx  <= r_bidx + 2'd1;
            if (w_blast) r_held <= 1'b0;
         end
         if (r_state == S_WAIT) begin
            if (w_rx_hs) begin
               r_result[{r_k, 3'b000} +: 8] <= rx_data_i;
               r_k <= r_k + 2'd1;
            end else if (w_tmr_done) begin
               r_timeout <= 1'b1;
            end else begin
               r_timer <= r_timer + TMR_W'(1);
            end
         end
      end
   end
endmodule

// File: doc/uart_alu_host.md
# uart_alu_host

Host-side command initiator for the UART ALU link. It accepts a command (opcode plus N 32-bit operands) on valid/ready streams, frames it into the ALU byte packet, and emits the bytes to a byte-wide uart_tx AXI-stream port. It then collects the 4-byte little-endian result from a uart_rx AXI-stream port and presents it as one 32-bit response. It is used as the bench/loopback driver and as the PC-side peer when both ends live on FPGA.

## Interface
- timeout_cycles_p, 1000000: cycles without a received byte in response wait before timeout; must be ≥ 1
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_opcode_i  in  8  opcode byte, passed through unchecked
- cmd_count_i  in  8  operand count N, 0..255
- op_valid_i  in  1  operand present
- op_ready_o  out  1  operand accepted when valid & ready
- op_data_i  in  32  operand value
- tx_data_o  out  8  byte to uart_tx
- tx_valid_o  out  1  byte valid
- tx_ready_i  in  1  uart_tx ready
- rx_data_i  in  8  byte from uart_rx
- rx_valid_i  in  1  byte valid
- rx_ready_o  out  1  byte consumed when valid & ready
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumer ready
- rsp_data_o  out  32  result
- rsp_timeout_o  out  1  qualifies rsp_valid_o: response timed out
- busy_o  out  1  high in any state other than IDLE

## Operation
- Packet: byte0 opcode, byte1 0x00, byte2 len[7:0], byte3 len[15:8], then N operands, each 4 bytes LSB first. len = 4 + 4·N as a 16-bit value (max 1024).
- Response: exactly 4 bytes, LSB first, assembled into rsp_data_o.
- States: IDLE, HDR, OPND, WAIT_RSP, RSP_OUT.
- IDLE: cmd_ready_o=1. On accept, latch opcode and N, compute len, and go to HDR with byte index 0.
- HDR: present header bytes 0..3 in order. Advance on tx_valid_o & tx_ready_i. After byte 3, go to OPND if N>0, else WAIT_RSP.
- OPND: op_ready_o=1 only while no operand is held. An accepted operand loads a 32-bit shift register, and its 4 bytes are sent LSB first. After the 4th byte of operand N, go to WAIT_RSP.
- WAIT_RSP: rx_ready_o=1. Each accepted byte fills result byte k (k=0..3). After k=3, go to RSP_OUT with rsp_timeout_o=0.
- Timeout counter clears on WAIT_RSP entry and on each accepted rx byte. When it reaches timeout_cycles_p, go to RSP_OUT with rsp_timeout_o=1. Unreceived result bytes read 0x00.
- RSP_OUT: rsp_valid_o=1 with data and timeout flag stable until rsp_ready_i. On handshake, go to IDLE.
- rx_ready_o=1 in IDLE, HDR and OPND. Bytes arriving there are discarded, so stray bytes never corrupt a later response. rx_ready_o=0 in RSP_OUT.
- tx_valid_o, once high, holds with tx_data_o stable until tx_ready_i. No byte is dropped or repeated.
- Reset (any state, asynchronous): state=IDLE, all outputs 0 except cmd_ready_o, which rises once reset deasserts (IDLE), and rx_ready_o, which reads 1 in IDLE. Counters, index and held registers clear. A partially sent packet is abandoned and is not resumed.

## Timing
- Command accepted at edge T: tx_valid_o=1 with the opcode from T+1.
- Back-to-back: with tx_ready_i held high, one byte per cycle, including across operand boundaries, provided op_valid_i is high when the operand register empties. The next operand may be accepted in the same cycle that the last byte of the current one handshakes.
- Final 4th rx byte accepted at edge T: rsp_valid_o=1 from T+1.
- Timeout: rsp_valid_o rises exactly timeout_cycles_p+1 cycles after the last WAIT_RSP entry or rx byte.
- rsp handshake at T: cmd_ready_o=1 from T+1.

## Test plan
- Opcode 0x01, N=2, operands 5 and 7, tx_ready_i=1 → tx bytes 01 00 0C 00 05 00 00 00 07 00 00 00 on consecutive cycles. Then rx 0C 00 00 00 → rsp_data_o=0x0000000C, rsp_timeout_o=0.
- Same command with tx_ready_i toggling randomly and op_valid_i delayed 10 cycles → identical byte sequence, and tx_data_o never changes while tx_valid_o=1 and tx_ready_i=0.
- N=0, opcode 0x7F → tx bytes 7F 00 04 00 only. Then rx 78 56 34 12 → rsp_data_o=0x12345678.
- timeout_cycles_p=50, rx only AA BB after the header → rsp_valid_o with rsp_timeout_o=1 and rsp_data_o=0x0000BBAA at the specified cycle.
- rx bytes 55 66 injected in IDLE and HDR, then correct response 01 00 00 00 → rsp_data_o=0x00000001.
- rst_i pulsed mid-OPND (after 6 bytes) → tx_valid_o drops asynchronously, busy_o=0. A new command then produces a complete, correct packet from byte 0.
